// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns: combinational GF(2^8) column mix, one output register.
// Ports: clk, rst (async active-low), in_valid, inv, data -> new_data, out_valid.
module mix_columns #(
  parameter int W_DATA = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              inv,
  input  logic [W_DATA-1:0] data,
  output logic [W_DATA-1:0] new_data,
  output logic              out_valid
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] b);
    return xt(b);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] b);
    return xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Row 0 of a column sits in the most significant byte.
  function automatic logic [31:0] mix_col(
    input logic [31:0] col,
    input logic        iv
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (iv) begin
      r0 = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
      r1 = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
      r2 = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
      r3 = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
    end else begin
      r0 = m2(a0) ^ m3(a1) ^ a2 ^ a3;
      r1 = a0 ^ m2(a1) ^ m3(a2) ^ a3;
      r2 = a0 ^ a1 ^ m2(a2) ^ m3(a3);
      r3 = m3(a0) ^ a1 ^ a2 ^ m2(a3);
    end
    return {r0, r1, r2, r3};
  endfunction

  logic [W_DATA-1:0] mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mixed[W_DATA-1-32*c -: 32] =
      mix_col(data[W_DATA-1-32*c -: 32], inv);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      new_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) new_data <= mixed;
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: directed AES vectors plus random
// forward/inverse round trips against a matrix-based GF(2^8) reference.
module tb_mix_columns;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         inv;
  logic [127:0] data;
  logic [127:0] new_data;
  logic         out_valid;

  int tests;
  int fails;

  mix_columns #(.W_DATA(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .inv      (inv),
    .data     (data),
    .new_data (new_data),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic peasant multiplication in GF(2^8) mod 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [8:0] t;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      t = {a, 1'b0};
      if (t[8]) t = t ^ 9'h11b;
      a = t[7:0];
    end
    return p;
  endfunction

  // State as a 4x4 matrix; each output column is M * column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
    logic [7:0] cf [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (iv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(cf[(j - r + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic iv, input logic v);
    data     = d;
    inv      = iv;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  logic [31:0]  vin  [6];
  logic [31:0]  vout [6];
  logic [127:0] s;
  logic [127:0] f;
  logic [127:0] held;

  initial begin
    tests = 0;
    fails = 0;
    vin[0] = 32'hdb135345; vout[0] = 32'h8e4da1bc;
    vin[1] = 32'hf20a225c; vout[1] = 32'h9fdc589d;
    vin[2] = 32'h01010101; vout[2] = 32'h01010101;
    vin[3] = 32'hc6c6c6c6; vout[3] = 32'hc6c6c6c6;
    vin[4] = 32'hd4d4d4d5; vout[4] = 32'hd5d5d7d6;
    vin[5] = 32'h2d26314c; vout[5] = 32'h4d7ebdf8;

    // Reset held with valid input present: nothing captured.
    rst      = 1'b0;
    in_valid = 1'b1;
    inv      = 1'b0;
    data     = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    #12;
    chk("rst_data", new_data, 128'h0);
    chk("rst_valid", {127'h0, out_valid}, 128'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Full FIPS-197 state.
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b1);
    chk("fips_fwd", new_data, 128'h046681e5e0cb199a48f8d37a2806264c);
    chk("fips_valid", {127'h0, out_valid}, 128'h1);
    send(128'h0123456789abcdef0123456789abcdef, 1'b1, 1'b0);
    chk("fips_hold", new_data, 128'h046681e5e0cb199a48f8d37a2806264c);
    chk("fips_vdrop", {127'h0, out_valid}, 128'h0);
    inv = 1'b0;
    @(posedge clk);
    #1;
    chk("inv_toggle_hold", new_data, 128'h046681e5e0cb199a48f8d37a2806264c);

    // Per-column forward vectors.
    for (int i = 0; i < 6; i++) begin
      send({4{vin[i]}}, 1'b0, 1'b1);
      chk("col_fwd", new_data, {4{vout[i]}});
    end

    // Inverse vectors.
    send(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1, 1'b1);
    chk("fips_inv", new_data, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    send({4{32'h8e4da1bc}}, 1'b1, 1'b1);
    chk("col_inv", new_data, {4{32'hdb135345}});

    // Streaming with alternating inv.
    for (int i = 0; i < 6; i++) begin
      send({4{vin[i]}}, i[0], 1'b1);
      chk("stream_data", new_data, ref_mix({4{vin[i]}}, i[0]));
      chk("stream_valid", {127'h0, out_valid}, 128'h1);
    end
    in_valid = 1'b0;

    // Asynchronous reset mid-operation.
    #2;
    rst = 1'b0;
    #1;
    chk("arst_data", new_data, 128'h0);
    chk("arst_valid", {127'h0, out_valid}, 128'h0);
    data     = 128'hffffffffffffffffffffffffffffffff;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_nocap", new_data, 128'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    send(128'h627a6f6644b109c82b18330a81c3b3e5, 1'b0, 1'b1);
    chk("post_rst_valid", {127'h0, out_valid}, 128'h1);
    chk("post_rst_fwd", new_data, ref_mix(128'h627a6f6644b109c82b18330a81c3b3e5, 1'b0));
    held = new_data;
    send(held, 1'b1, 1'b1);
    chk("post_rst_inv", new_data, 128'h627a6f6644b109c82b18330a81c3b3e5);

    // Random round trips.
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      send(s, 1'b0, 1'b1);
      chk("rand_fwd", new_data, ref_mix(s, 1'b0));
      f = new_data;
      send(f, 1'b1, 1'b1);
      chk("rand_rt", new_data, s);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("final_vdrop", {127'h0, out_valid}, 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mix_columns.md
MIX_COLUMNS -- requirements
Module: mix_columns

Interface
REQ-001 Parameter: W_DATA, default 128, state width in bits; only 128 is supported.
REQ-002 Port: clk  input  1  rising-edge clock; the block has exactly one clock.
REQ-003 Port: rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-004 Port: in_valid  input  1  qualifies data for capture on the current clk edge.
REQ-005 Port: inv  input  1  0 = forward MixColumns, 1 = InvMixColumns; sampled with data.
REQ-006 Port: data  input  W_DATA  AES state in.
REQ-007 Port: new_data  output  W_DATA  transformed state, registered.
REQ-008 Port: out_valid  output  1  high for one cycle when new_data carries a fresh result.

Function
REQ-009 The state byte order SHALL be FIPS-197 column-major, MSB first:
- byte k occupies bits [127-8k : 120-8k];
- column c is bytes 4c..4c+3, so column 0 is bits [127:96];
- row r of a column is byte 4c+r.
REQ-010 The four columns SHALL be transformed independently, each as a 4-byte column vector multiplied by a fixed matrix over GF(2^8) with reduction polynomial 0x11B.
REQ-011 Forward mode SHALL use matrix rows [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
REQ-012 Inverse mode SHALL use matrix rows [0E 0B 0D 09], [09 0E 0B 0D], [0D 09 0E 0B], [0B 0D 09 0E].
REQ-013 GF multiply SHALL be built from xtime: shift left 1, then XOR 0x1B if the shifted-out bit was 1. Addition SHALL be XOR. No lookup tables and no integer carries.
REQ-014 The computation SHALL be purely combinational from data and inv into a single output register stage.
REQ-015 On a rising clk edge with rst high and in_valid=1:
- new_data SHALL load the transform of data;
- out_valid SHALL load 1.
Latency is 1 cycle and throughput is one state per cycle. Back-to-back in_valid SHALL be accepted every cycle with no stall.
REQ-016 On a rising clk edge with in_valid=0:
- new_data SHALL hold its previous value;
- out_valid SHALL load 0.
REQ-017 inv SHALL be sampled only together with data on a capturing edge. Changing inv between captures SHALL NOT alter a held new_data.
REQ-018 Applying forward then inverse to any state SHALL return the original state exactly.
REQ-019 Outputs SHALL NOT depend combinationally on any input.

Reset
REQ-020 While rst=0, new_data SHALL be 0 and out_valid SHALL be 0, asynchronously and independent of clk.
REQ-021 If rst asserts mid-operation, any pending result SHALL be discarded. The first in_valid after rst deasserts SHALL produce out_valid exactly one cycle later.
REQ-022 No input SHALL be captured on a clk edge while rst=0.

Verification
REQ-023 Full state, inv=0: data=d4bf5d30e0b452aeb84111f11e2798e5, in_valid for one cycle -> next cycle new_data=046681e5e0cb199a48f8d37a2806264c and out_valid=1; the cycle after, out_valid=0 with new_data held.
REQ-024 Per-column forward vectors, each replicated in all four columns, inv=0:
- db135345 -> 8e4da1bc
- f20a225c -> 9fdc589d
- 01010101 -> 01010101
- c6c6c6c6 -> c6c6c6c6
- d4d4d4d5 -> d5d5d7d6
- 2d26314c -> 4d7ebdf8
REQ-025 Inverse: inv=1 with data=046681e5e0cb199a48f8d37a2806264c -> new_data=d4bf5d30e0b452aeb84111f11e2798e5. Column 8e4da1bc -> db135345.
REQ-026 Streaming: apply the 6 column vectors on 6 consecutive cycles with inv alternating 0/1 -> out_valid stays high for 6 cycles, and each result matches its own input and its own inv value.
REQ-027 Reset: drive rst=0 asynchronously between clk edges while new_data is nonzero -> new_data=0 and out_valid=0 immediately. Release rst, then present data=627a6f6644b109c82b18330a81c3b3e5 with inv=0 -> result is produced after 1 cycle. Re-apply that result with inv=1 -> new_data returns 627a6f6644b109c82b18330a81c3b3e5.
REQ-028 Randomized: at least 1000 random states, each sent through forward then inverse -> output equals input. Forward results SHALL also match a software reference model.
